// File: rtl/cpu_nios_key_in.sv
// ============================================================================
// Module   : cpu_nios_key_in
// Purpose  : Avalon-MM key/switch input port with sync, debounce, edge capture
//            and masked interrupt.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_nios_key_in #(
    parameter int          WIDTH           = 4,
    parameter int          DEBOUNCE_CYCLES = 50000,
    parameter logic [31:0] RESET_VALUE     = 32'hF,
    parameter int          EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int               CNT_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] RST_STATE = RESET_VALUE[WIDTH-1:0];

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] mask;
    logic             wr_en;
    logic             unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign unused_wdata = ^writedata;

    // Sync stages reset to the idle level so release does not look like an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= RST_STATE;
            sync2 <= RST_STATE;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            logic [CNT_W-1:0] cnt;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt <= '0;
                end else if (sync2[i] == state[i] || cnt == CNT_MAX) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign accept[i] = (sync2[i] != state[i]) && (cnt == CNT_MAX);
        end
    endgenerate

    generate
        if (EDGE_TYPE == 0) begin : g_fall
            assign edge_set = accept & ~sync2;
        end else if (EDGE_TYPE == 1) begin : g_rise
            assign edge_set = accept & sync2;
        end else begin : g_any
            assign edge_set = accept;
        end
    endgenerate

    assign edge_clr = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= RST_STATE;
            mask     <= '0;
            edge_cap <= '0;
        end else begin
            state <= state ^ accept;
            if (wr_en && address == ADDR_MASK) begin
                mask <= writedata[WIDTH-1:0];
            end
            // Set is ORed in after the clear so a coincident capture survives.
            edge_cap <= (edge_cap & ~edge_clr) | edge_set;
        end
    end

    assign irq = |(edge_cap & mask);

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA: readdata[WIDTH-1:0] = state;
            ADDR_MASK: readdata[WIDTH-1:0] = mask;
            ADDR_EDGE: readdata[WIDTH-1:0] = edge_cap;
            default:   readdata = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_cpu_nios_key_in.sv
// ============================================================================
// Module   : tb_cpu_nios_key_in
// Purpose  : Directed self-checking bench for cpu_nios_key_in (falling-edge
//            and any-edge instances side by side).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_nios_key_in;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] rd_fall;
    logic [31:0] rd_any;
    logic        irq_fall;
    logic        irq_any;

    int compared;
    int mismatched;

    cpu_nios_key_in #(
        .WIDTH(4), .DEBOUNCE_CYCLES(4), .RESET_VALUE(32'hF), .EDGE_TYPE(0)
    ) u_dut_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_fall), .irq(irq_fall)
    );

    cpu_nios_key_in #(
        .WIDTH(4), .DEBOUNCE_CYCLES(4), .RESET_VALUE(32'hF), .EDGE_TYPE(2)
    ) u_dut_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_any), .irq(irq_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Combinational read; no clock edge consumed.
    task automatic rd(input logic [1:0] a, output logic [31:0] df, output logic [31:0] da);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        df = rd_fall;
        da = rd_any;
    endtask

    // Called between edges; the write lands on the following posedge.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic test_reset;
        logic [31:0] df, da;
        reset_n = 1'b0;
        in_port = 4'hF;
        cyc(3);
        reset_n = 1'b1;
        cyc(1);
        rd(2'd0, df, da);
        compared++;
        if (df !== 32'hF) begin mismatched++; $display("FAIL reset_data got %h want %h", df, 32'hF); end
        rd(2'd1, df, da);
        compared++;
        if (df !== 32'h0) begin mismatched++; $display("FAIL reset_rsvd got %h want %h", df, 32'h0); end
        rd(2'd2, df, da);
        compared++;
        if (df !== 32'h0) begin mismatched++; $display("FAIL reset_mask got %h want %h", df, 32'h0); end
        rd(2'd3, df, da);
        compared++;
        if (df !== 32'h0 || da !== 32'h0) begin mismatched++; $display("FAIL reset_edge got %h/%h want 0/0", df, da); end
        compared++;
        if (irq_fall !== 1'b0 || irq_any !== 1'b0) begin mismatched++; $display("FAIL reset_irq got %b/%b want 0/0", irq_fall, irq_any); end
    endtask

    task automatic test_debounce_capture;
        logic [31:0] df, da;
        in_port = 4'hE;
        cyc(5);
        rd(2'd0, df, da);
        compared++;
        if (df !== 32'hF) begin mismatched++; $display("FAIL latency_early got %h want %h", df, 32'hF); end
        cyc(1);
        rd(2'd0, df, da);
        compared++;
        if (df !== 32'hE) begin mismatched++; $display("FAIL latency_data got %h want %h", df, 32'hE); end
        rd(2'd3, df, da);
        compared++;
        if (df !== 32'h1) begin mismatched++; $display("FAIL capture_edge got %h want %h", df, 32'h1); end
        cyc(4);
        compared++;
        if (irq_fall !== 1'b0) begin mismatched++; $display("FAIL masked_irq got %b want 0", irq_fall); end
        wr(2'd2, 32'h1);
        #1;
        compared++;
        if (irq_fall !== 1'b1) begin mismatched++; $display("FAIL mask_irq got %b want 1", irq_fall); end
        rd(2'd2, df, da);
        compared++;
        if (df !== 32'h1) begin mismatched++; $display("FAIL mask_read got %h want %h", df, 32'h1); end
        wr(2'd0, 32'h0);
        rd(2'd0, df, da);
        compared++;
        if (df !== 32'hE) begin mismatched++; $display("FAIL data_ro got %h want %h", df, 32'hE); end
    endtask

    task automatic test_glitch;
        logic [31:0] df, da;
        in_port = 4'hC;
        cyc(3);
        in_port = 4'hE;
        cyc(10);
        rd(2'd0, df, da);
        compared++;
        if (df !== 32'hE) begin mismatched++; $display("FAIL glitch_data got %h want %h", df, 32'hE); end
        rd(2'd3, df, da);
        compared++;
        if (df !== 32'h1) begin mismatched++; $display("FAIL glitch_edge got %h want %h", df, 32'h1); end
        compared++;
        if (irq_fall !== 1'b1) begin mismatched++; $display("FAIL glitch_irq got %b want 1", irq_fall); end
    endtask

    task automatic test_w1c;
        logic [31:0] df, da;
        wr(2'd3, 32'h1);
        rd(2'd3, df, da);
        compared++;
        if (df !== 32'h0) begin mismatched++; $display("FAIL w1c_edge got %h want %h", df, 32'h0); end
        compared++;
        if (irq_fall !== 1'b0) begin mismatched++; $display("FAIL w1c_irq got %b want 0", irq_fall); end
        // Release: rising edge must not be captured by the falling-edge port.
        in_port = 4'hF;
        cyc(8);
        rd(2'd3, df, da);
        compared++;
        if (df !== 32'h0) begin mismatched++; $display("FAIL rise_ignored got %h want %h", df, 32'h0); end
        // Press again and clear in the very cycle the capture happens.
        in_port = 4'hE;
        cyc(5);
        wr(2'd3, 32'h1);
        rd(2'd3, df, da);
        compared++;
        if (df !== 32'h1) begin mismatched++; $display("FAIL set_wins got %h want %h", df, 32'h1); end
        compared++;
        if (irq_fall !== 1'b1) begin mismatched++; $display("FAIL set_wins_irq got %b want 1", irq_fall); end
    endtask

    task automatic test_edge_types;
        logic [31:0] df, da;
        wr(2'd3, 32'hF);
        rd(2'd3, df, da);
        compared++;
        if (df !== 32'h0 || da !== 32'h0) begin mismatched++; $display("FAIL clear_all got %h/%h want 0/0", df, da); end
        in_port = 4'hA;
        cyc(8);
        rd(2'd3, df, da);
        compared++;
        if (df !== 32'h4 || da !== 32'h4) begin mismatched++; $display("FAIL fall_capture got %h/%h want 4/4", df, da); end
        wr(2'd3, 32'h4);
        in_port = 4'hE;
        cyc(8);
        rd(2'd0, df, da);
        compared++;
        if (df !== 32'hE) begin mismatched++; $display("FAIL edge_data got %h want %h", df, 32'hE); end
        rd(2'd3, df, da);
        compared++;
        if (df !== 32'h0) begin mismatched++; $display("FAIL rise_fall_port got %h want %h", df, 32'h0); end
        compared++;
        if (da !== 32'h4) begin mismatched++; $display("FAIL rise_any_port got %h want %h", da, 32'h4); end
        compared++;
        if (irq_any !== 1'b0) begin mismatched++; $display("FAIL any_irq_masked got %b want 0", irq_any); end
        wr(2'd2, 32'h4);
        #1;
        compared++;
        if (irq_any !== 1'b1 || irq_fall !== 1'b0) begin mismatched++; $display("FAIL any_irq got %b/%b want 1/0", irq_any, irq_fall); end
    endtask

    task automatic test_reset_mid_debounce;
        logic [31:0] df, da;
        in_port = 4'h6;
        cyc(4);
        reset_n = 1'b0;
        #1;
        rd(2'd0, df, da);
        compared++;
        if (df !== 32'hF) begin mismatched++; $display("FAIL async_reset_data got %h want %h", df, 32'hF); end
        rd(2'd2, df, da);
        compared++;
        if (df !== 32'h0 || irq_any !== 1'b0) begin mismatched++; $display("FAIL async_reset_mask got %h irq %b want 0 irq 0", df, irq_any); end
        cyc(2);
        reset_n = 1'b1;
        cyc(5);
        rd(2'd0, df, da);
        compared++;
        if (df !== 32'hF) begin mismatched++; $display("FAIL post_reset_early got %h want %h", df, 32'hF); end
        cyc(1);
        rd(2'd0, df, da);
        compared++;
        if (df !== 32'h6) begin mismatched++; $display("FAIL post_reset_data got %h want %h", df, 32'h6); end
        rd(2'd3, df, da);
        compared++;
        if (df !== 32'h9 || da !== 32'h9) begin mismatched++; $display("FAIL post_reset_edge got %h/%h want 9/9", df, da); end
        compared++;
        if (irq_fall !== 1'b0) begin mismatched++; $display("FAIL post_reset_irq got %b want 0", irq_fall); end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 4'hF;
        test_reset();
        test_debounce_capture();
        test_glitch();
        test_w1c();
        test_edge_types();
        test_reset_mid_debounce();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
